// File: rtl/alloc_retirer_pkg.sv
// Shared configuration for the allocation retirer.
// Provides buffer geometry, config count and retire FSM states.
package TauCfg;

    localparam int LOCAL_ADDR_BW0     = 5;
    localparam int N_ICFG             = 3;
    localparam int ALLOC_RETIRE_DEPTH = 4;

    typedef enum logic {
        RUN,
        DRAIN
    } RetireState_t;

endpackage

// File: rtl/alloc_id_fifo.sv
// Register FIFO holding outstanding allocations in grant order.
// Ports: clk/rst, push/din, pop/dout (head entry), full, empty, cnt.
module alloc_id_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/alloc_retirer.sv
// Accepts allocator grants, presents the oldest to the reader, frees on retire.
// Ports: linear_* grant handshake, head_* reader side, free/blkdone pulses, o_inuse.
module alloc_retirer
    import TauCfg::*;
#(
    parameter int LBW     = LOCAL_ADDR_BW0,
    parameter int DEPTH   = ALLOC_RETIRE_DEPTH,
    localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_ICFG-1:0][LBW:0]    i_sizes,
    input  logic                        linear_rdy,
    output logic                        linear_ack,
    input  logic [LBW-1:0]              i_linear,
    input  logic [ICFG_BW-1:0]          i_linear_id,
    output logic                        head_rdy,
    input  logic                        head_ack,
    output logic [LBW-1:0]              o_head_linear,
    output logic [ICFG_BW-1:0]          o_head_id,
    output logic                        free_dval,
    output logic [ICFG_BW-1:0]          o_free_id,
    input  logic                        blkend_dval,
    output logic                        blkdone_dval,
    output logic [LBW:0]                o_inuse
);

    localparam int W  = LBW + ICFG_BW;
    localparam int CW = $clog2(DEPTH) + 1;

    RetireState_t  state_q;
    RetireState_t  state_d;
    logic          blkdone_d;
    logic          full;
    logic          empty;
    logic [CW-1:0] cnt;
    logic [W-1:0]  head_ent;
    logic          pop;
    logic [LBW:0]  push_size;
    logic [LBW:0]  pop_size;

    // Gated by reset so the handshake reads idle while reset is held.
    assign linear_ack = !i_rst && linear_rdy && !full && (state_q == RUN);
    assign head_rdy   = !empty;
    assign pop        = head_ack && head_rdy;

    assign {o_head_linear, o_head_id} = head_ent;

    alloc_id_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (linear_ack),
        .din   ({i_linear, i_linear_id}),
        .pop   (pop),
        .dout  (head_ent),
        .full  (full),
        .empty (empty),
        .cnt   (cnt)
    );

    // Explicit compare loop keeps unused id codes from indexing past the table.
    always_comb begin
        push_size = '0;
        pop_size  = '0;
        for (int i = 0; i < N_ICFG; i++) begin
            if (i_linear_id == ICFG_BW'(i)) begin
                push_size = i_sizes[i];
            end
            if (o_head_id == ICFG_BW'(i)) begin
                pop_size = i_sizes[i];
            end
        end
    end

    // Waiting on free_dval keeps blkdone strictly after the final free pulse.
    always_comb begin
        state_d   = state_q;
        blkdone_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (blkend_dval) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && !free_dval) begin
                    blkdone_d = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= RUN;
            blkdone_dval <= 1'b0;
            free_dval    <= 1'b0;
            o_free_id    <= '0;
            o_inuse      <= '0;
        end else begin
            state_q      <= state_d;
            blkdone_dval <= blkdone_d;
            free_dval    <= pop;
            if (pop) begin
                o_free_id <= o_head_id;
            end
            o_inuse <= o_inuse
                     + (linear_ack ? push_size : '0)
                     - (pop ? pop_size : '0);
        end
    end

endmodule

// File: tb/tb_alloc_retirer.sv
// Directed bench for alloc_retirer with a queue-based reference model.
// Per-cycle compare process plus literal checks pinning each scenario.
module tb_alloc_retirer;
    import TauCfg::*;

    localparam int LBW   = LOCAL_ADDR_BW0;
    localparam int BW    = $clog2(N_ICFG + 1);
    localparam int DEPTH = ALLOC_RETIRE_DEPTH;
    localparam int MASK  = (1 << (LBW + 1)) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_ICFG-1:0][LBW:0] sizes;
    logic                     linear_rdy;
    logic                     linear_ack;
    logic [LBW-1:0]           lin;
    logic [BW-1:0]            lin_id;
    logic                     head_rdy;
    logic                     head_ack;
    logic [LBW-1:0]           head_lin;
    logic [BW-1:0]            head_id;
    logic                     free_dval;
    logic [BW-1:0]            free_id;
    logic                     blkend;
    logic                     blkdone;
    logic [LBW:0]             inuse;

    int tests = 0;
    int fails = 0;

    int sz [N_ICFG] = '{4, 8, 2};

    typedef struct {
        int lin;
        int id;
    } ent_t;

    ent_t q [$];
    int   m_inuse = 0;
    bit   m_free  = 0;
    int   m_fid   = 0;
    bit   m_done  = 0;
    bit   m_drain = 0;

    always #5 clk = ~clk;

    alloc_retirer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sizes       (sizes),
        .linear_rdy    (linear_rdy),
        .linear_ack    (linear_ack),
        .i_linear      (lin),
        .i_linear_id   (lin_id),
        .head_rdy      (head_rdy),
        .head_ack      (head_ack),
        .o_head_linear (head_lin),
        .o_head_id     (head_id),
        .free_dval     (free_dval),
        .o_free_id     (free_id),
        .blkend_dval   (blkend),
        .blkdone_dval  (blkdone),
        .o_inuse       (inuse)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic grant(input bit r, input int a, input int id);
        linear_rdy = r;
        lin        = LBW'(a);
        lin_id     = BW'(id);
    endtask

    // Reference model: sampled mid-cycle, advanced to the next cycle's state.
    initial begin
        bit e_ack;
        bit pop;
        bit done_n;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                chk("m_rst_ack", linear_ack, 0);
                chk("m_rst_head", head_rdy, 0);
                chk("m_rst_free", free_dval, 0);
                chk("m_rst_fid", free_id, 0);
                chk("m_rst_done", blkdone, 0);
                chk("m_rst_inuse", inuse, 0);
                q.delete();
                m_inuse = 0;
                m_free  = 0;
                m_fid   = 0;
                m_done  = 0;
                m_drain = 0;
            end else begin
                e_ack = linear_rdy && (q.size() < DEPTH) && !m_drain;
                chk("m_ack", linear_ack, e_ack);
                chk("m_head_rdy", head_rdy, q.size() > 0);
                if (q.size() > 0) begin
                    chk("m_head_lin", head_lin, q[0].lin);
                    chk("m_head_id", head_id, q[0].id);
                end
                chk("m_free", free_dval, m_free);
                chk("m_fid", free_id, m_fid);
                chk("m_done", blkdone, m_done);
                chk("m_inuse", inuse, m_inuse);

                pop    = head_ack && (q.size() > 0);
                done_n = m_drain && (q.size() == 0) && !m_free;
                if (m_drain) m_drain = !done_n;
                else         m_drain = blkend;
                if (pop) begin
                    m_fid   = q[0].id;
                    m_inuse = m_inuse - sz[q[0].id];
                    void'(q.pop_front());
                end
                m_free = pop;
                if (e_ack) begin
                    q.push_back('{int'(lin), int'(lin_id)});
                    m_inuse = m_inuse + sz[lin_id];
                end
                m_inuse = m_inuse & MASK;
                m_done  = done_n;
            end
        end
    end

    initial begin
        rst      = 1'b1;
        sizes[0] = (LBW+1)'(4);
        sizes[1] = (LBW+1)'(8);
        sizes[2] = (LBW+1)'(2);
        grant(0, 0, 0);
        head_ack = 1'b0;
        blkend   = 1'b0;
        tick;
        tick;
        chk("reset_head_rdy", head_rdy, 0);
        chk("reset_inuse", inuse, 0);
        chk("reset_free", free_dval, 0);
        rst = 1'b0;
        tick;

        // single allocation
        grant(1, 0, 1);
        tick;
        chk("single_head_rdy", head_rdy, 1);
        chk("single_head_lin", head_lin, 0);
        chk("single_head_id", head_id, 1);
        chk("single_inuse", inuse, 8);
        grant(0, 0, 0);
        head_ack = 1'b1;
        tick;
        chk("single_free", free_dval, 1);
        chk("single_fid", free_id, 1);
        chk("single_inuse0", inuse, 0);
        head_ack = 1'b0;
        tick;
        chk("single_free_1cyc", free_dval, 0);
        chk("single_fid_kept", free_id, 1);

        // fill to DEPTH
        grant(1, 0, 0);  tick;
        grant(1, 4, 1);  tick;
        grant(1, 12, 2); tick;
        grant(1, 14, 0); tick;
        chk("full_ack_low", linear_ack, 0);
        chk("full_inuse", inuse, 18);
        chk("full_head_id", head_id, 0);
        head_ack = 1'b1;
        tick;
        chk("full_ack_back", linear_ack, 1);
        grant(0, 0, 0);
        chk("full_fid0", free_id, 0);
        chk("full_h1", {head_lin, head_id}, {5'd4, 2'd1});
        chk("full_inuse1", inuse, 14);
        tick;
        chk("full_h2", {head_lin, head_id}, {5'd12, 2'd2});
        chk("full_inuse2", inuse, 6);
        tick;
        chk("full_h3", {head_lin, head_id}, {5'd14, 2'd0});
        chk("full_inuse3", inuse, 4);
        tick;
        chk("full_empty", head_rdy, 0);
        chk("full_inuse4", inuse, 0);
        head_ack = 1'b0;
        tick;

        // simultaneous push and pop at cnt=2
        grant(1, 0, 0); tick;
        grant(1, 4, 1); tick;
        chk("sim_inuse_pre", inuse, 12);
        grant(1, 12, 2);
        head_ack = 1'b1;
        tick;
        chk("sim_free", free_dval, 1);
        chk("sim_fid", free_id, 0);
        chk("sim_inuse", inuse, 10);
        chk("sim_head", {head_lin, head_id}, {5'd4, 2'd1});
        grant(1, 14, 0);
        head_ack = 1'b0;
        tick;
        chk("sim_inuse3", inuse, 14);
        grant(0, 0, 0);

        // drain three entries
        blkend = 1'b1;
        tick;
        blkend = 1'b0;
        grant(1, 20, 1);
        tick;
        chk("drain_ack_low", linear_ack, 0);
        head_ack = 1'b1;
        tick;
        chk("drain_f1", {free_dval, free_id}, {1'b1, 2'd1});
        tick;
        chk("drain_f2", {free_dval, free_id}, {1'b1, 2'd2});
        tick;
        chk("drain_f3", {free_dval, free_id}, {1'b1, 2'd0});
        chk("drain_no_early", blkdone, 0);
        chk("drain_inuse0", inuse, 0);
        head_ack = 1'b0;
        tick;
        chk("drain_gap", {free_dval, blkdone, linear_ack}, 3'b000);
        tick;
        chk("drain_done", blkdone, 1);
        chk("drain_ack_resume", linear_ack, 1);
        grant(0, 0, 0);
        tick;
        chk("drain_done_1cyc", blkdone, 0);

        // block end with empty FIFO
        blkend = 1'b1;
        tick;
        blkend = 1'b0;
        chk("eblk_t1", blkdone, 0);
        tick;
        chk("eblk_t2", blkdone, 1);
        chk("eblk_nofree", free_dval, 0);
        tick;
        chk("eblk_t3", blkdone, 0);

        // reset mid-drain with two entries
        grant(1, 0, 0); tick;
        grant(1, 4, 1); tick;
        grant(0, 0, 0);
        blkend = 1'b1;
        tick;
        blkend = 1'b0;
        tick;
        chk("rstm_pre_head", head_rdy, 1);
        #1;
        rst = 1'b1;
        grant(1, 8, 2);
        #1;
        chk("rstm_head", head_rdy, 0);
        chk("rstm_inuse", inuse, 0);
        chk("rstm_ack", linear_ack, 0);
        chk("rstm_done", blkdone, 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        grant(0, 0, 0);
        chk("rstm_fresh", {head_rdy, head_lin, head_id}, {1'b1, 5'd8, 2'd2});
        chk("rstm_fresh_inuse", inuse, 2);
        tick;
        tick;
        chk("rstm_no_done", blkdone, 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
